// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchronizer and one-entry valid/ready holding register.
// Start bit is confirmed at mid-bit; data and stop bits are then sampled one full bit period apart.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             shreg_q, shreg_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   rxs;
   logic                   stop_smp;

   assign rxs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         sync_q      <= '1;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], rx_i};
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      shreg_d = shreg_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shreg_d = {rxs, shreg_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = rxs ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            // A held-low line (break) must not retrigger a frame until it returns high.
            cnt_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      stop_smp    = (state_q == STOP) && (cnt_q == FULL_M1);
      data_d      = data_q;
      valid_d     = valid_q & ~ready_i;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      if (stop_smp && rxs) begin
         if (!valid_q || ready_i) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
      if (stop_smp && !rxs) frame_err_d = 1'b1;
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       rx_i = 1'b1;
   logic       ready_i = 1'b1;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       overrun_o;

   uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] acc_q[$];
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         vh_cnt = 0;
   int         rise_cyc = 0;
   logic       vprev = 1'b0;

   always @(negedge clk) begin
      if (rst_ni) begin
         if (valid_o && ready_i) acc_q.push_back(data_o);
         if (frame_err_o) fe_cnt = fe_cnt + 1;
         if (overrun_o) ov_cnt = ov_cnt + 1;
         if (valid_o) vh_cnt = vh_cnt + 1;
         if (valid_o && !vprev) rise_cyc = cyc;
      end
      vprev = valid_o;
   end

   int vectors = 0;
   int miscompares = 0;
   int start_cyc = 0;
   int acc_base, fe_base, ov_base, vh_base, lat;

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      start_cyc = cyc;
      rx_i = 1'b0;
      ticks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         ticks(CPB);
      end
      rx_i = stop;
      ticks(CPB);
   endtask

   task automatic snap();
      acc_base = acc_q.size();
      fe_base  = fe_cnt;
      ov_base  = ov_cnt;
      vh_base  = vh_cnt;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] acc_at(input int k);
      if (k < acc_q.size()) return {24'h0, acc_q[k]};
      return 32'hdead;
   endfunction

   initial begin
      #12;
      check("rst_data", data_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_ferr", frame_err_o, 0);
      check("rst_ovr", overrun_o, 0);
      @(posedge clk);
      #2;
      rst_ni = 1'b1;
      ticks(20);

      // 1: single byte, latency
      snap();
      send_byte(8'hA5, 1'b1);
      ticks(20);
      lat = rise_cyc - start_cyc;
      check("t1_count", acc_q.size() - acc_base, 1);
      check("t1_data", acc_at(acc_base), 8'hA5);
      check("t1_ferr", fe_cnt - fe_base, 0);
      check("t1_ovr", ov_cnt - ov_base, 0);
      check("t1_vcycles", vh_cnt - vh_base, 1);
      check("t1_latency", (lat >= 154 && lat <= 156), 1);

      // 2: back-to-back frames
      snap();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      ticks(20);
      check("t2_count", acc_q.size() - acc_base, 2);
      check("t2_first", acc_at(acc_base), 8'h00);
      check("t2_second", acc_at(acc_base + 1), 8'hFF);
      check("t2_errs", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);

      // 3: overrun while consumer stalls
      ready_i = 1'b0;
      snap();
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      ticks(20);
      check("t3_valid_held", valid_o, 1);
      check("t3_data_held", data_o, 8'h12);
      check("t3_ovr", ov_cnt - ov_base, 1);
      check("t3_none_acc", acc_q.size() - acc_base, 0);
      ready_i = 1'b1;
      ticks(1);
      check("t3_valid_fall", valid_o, 0);
      ticks(2);
      check("t3_acc_count", acc_q.size() - acc_base, 1);
      check("t3_acc_data", acc_at(acc_base), 8'h12);

      // 4: framing error, break, recovery
      snap();
      send_byte(8'h5A, 1'b0);
      ticks(40 * CPB);
      check("t4_ferr_once", fe_cnt - fe_base, 1);
      check("t4_no_valid", valid_o, 0);
      check("t4_no_acc", acc_q.size() - acc_base, 0);
      rx_i = 1'b1;
      ticks(2 * CPB);
      send_byte(8'h3C, 1'b1);
      ticks(20);
      check("t4_rx_count", acc_q.size() - acc_base, 1);
      check("t4_rx_data", acc_at(acc_base), 8'h3C);
      check("t4_ferr_total", fe_cnt - fe_base, 1);

      // 5: short glitch is rejected
      snap();
      rx_i = 1'b0;
      ticks(3);
      rx_i = 1'b1;
      ticks(3 * CPB);
      check("t5_glitch_acc", acc_q.size() - acc_base, 0);
      check("t5_glitch_ferr", fe_cnt - fe_base, 0);
      send_byte(8'h81, 1'b1);
      ticks(20);
      check("t5_rx_count", acc_q.size() - acc_base, 1);
      check("t5_rx_data", acc_at(acc_base), 8'h81);

      // 6: reset mid-frame with a byte held
      ready_i = 1'b0;
      send_byte(8'h55, 1'b1);
      ticks(10);
      check("t6_pre_valid", valid_o, 1);
      rx_i = 1'b0;
      ticks(CPB);
      rx_i = 1'b1;
      ticks(CPB);
      rx_i = 1'b0;
      ticks(CPB / 2);
      rst_ni = 1'b0;
      #1;
      check("t6_rst_valid", valid_o, 0);
      check("t6_rst_data", data_o, 0);
      check("t6_rst_ferr", frame_err_o, 0);
      check("t6_rst_ovr", overrun_o, 0);
      rx_i = 1'b1;
      ticks(5);
      rst_ni = 1'b1;
      ready_i = 1'b1;
      ticks(3 * CPB);
      snap();
      send_byte(8'hC3, 1'b1);
      ticks(20);
      check("t6_rx_count", acc_q.size() - acc_base, 1);
      check("t6_rx_data", acc_at(acc_base), 8'hC3);
      check("t6_errs", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
